// File: rtl/demux_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux_pkg : shared constants and one-hot helper for demux_1to4  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package demux_pkg;
  localparam int SEL_W     = 2;
  localparam int NUM_LANES = 4;

  // Shift form keeps an X select visible as X rather than folding it to a lane
  function automatic logic [NUM_LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
    return 4'b0001 << sel;
  endfunction
endpackage
`default_nettype wire

// File: rtl/demux_1to4_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux_1to4_if : data/select/enable in, four lanes + strobes out |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface demux_1to4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0]   d;
  logic [1:0]         sel;
  logic               en;
  logic [4*WIDTH-1:0] y;
  logic [3:0]         y_valid;

  modport master (output d, output sel, output en, input y, input y_valid);
  modport slave  (input d, input sel, input en, output y, output y_valid);
endinterface
`default_nettype wire

// File: rtl/demux_decode_2to4.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux_decode_2to4 : combinational lane steering and strobe      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module demux_decode_2to4
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]           d,
  input  logic [SEL_W-1:0]           sel,
  output logic [NUM_LANES*WIDTH-1:0] lanes,
  output logic [NUM_LANES-1:0]       strobe
);
  assign strobe = onehot4(sel);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lanes[k*WIDTH +: WIDTH] = d & {WIDTH{strobe[k]}};
  end
endmodule
`default_nettype wire

// File: rtl/demux_1to4.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | demux_1to4 : 1-to-4 demux with per-lane valid, optional flop    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_1to4_if.slave  bus
);
  logic [NUM_LANES*WIDTH-1:0] w_lanes;
  logic [NUM_LANES-1:0]       w_strobe;

  demux_decode_2to4 #(.WIDTH(WIDTH)) u_decode (
    .d      (bus.d),
    .sel    (bus.sel),
    .lanes  (w_lanes),
    .strobe (w_strobe)
  );

  if (REGISTERED) begin : g_reg
    logic [NUM_LANES*WIDTH-1:0] r_y;
    logic [NUM_LANES-1:0]       r_y_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_y       <= '0;
        r_y_valid <= '0;
      end else if (bus.en) begin
        r_y       <= w_lanes;
        r_y_valid <= w_strobe;
      end
    end

    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
  end else begin : g_comb
    // Clock, reset and enable have no role on the pure combinational path
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, bus.en};

    assign bus.y       = w_lanes;
    assign bus.y_valid = w_strobe;
  end
endmodule
`default_nettype wire

// File: tb/tb_demux_1to4.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_demux_1to4 : directed bench, registered W=1/W=8 and comb W=1 |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_demux_1to4;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  demux_1to4_if #(.WIDTH(1)) bus1 ();
  demux_1to4_if #(.WIDTH(8)) bus8 ();
  demux_1to4_if #(.WIDTH(1)) busc ();

  demux_1to4 #(.WIDTH(1), .REGISTERED(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  demux_1to4 #(.WIDTH(8), .REGISTERED(1'b1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  demux_1to4 #(.WIDTH(1), .REGISTERED(1'b0)) dutc (.clk(clk), .rst_n(rst_n), .bus(busc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus1.d = 1'b1; bus1.sel = 2'd1; bus1.en = 1'b1;
    bus8.d = 8'h00; bus8.sel = 2'd0; bus8.en = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (bus1.y !== 4'b0000 || bus1.y_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_initial y=%b v=%b want 0000/0000", bus1.y, bus1.y_valid);
    end
    #3 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus1.y !== 4'b0010 || bus1.y_valid !== 4'b0010) begin
      n_err++; $display("FAIL reset_first_load y=%b v=%b want 0010/0010", bus1.y, bus1.y_valid);
    end
    // Assert between edges with a different pending update on the inputs
    bus1.sel = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus1.y !== 4'b0000 || bus1.y_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_async y=%b v=%b want 0000/0000", bus1.y, bus1.y_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus1.y !== 4'b0000 || bus1.y_valid !== 4'b0000) begin
        n_err++; $display("FAIL reset_hold[%0d] y=%b v=%b want 0000/0000", i, bus1.y, bus1.y_valid);
      end
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [3:0] exp;
    bus1.d = 1'b1; bus1.en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bus1.sel = 2'(s);
      tick();
      exp = 4'b0001 << s;
      n_cmp++;
      if (bus1.y !== exp || bus1.y_valid !== exp) begin
        n_err++; $display("FAIL sweep sel=%0d y=%b v=%b want %b/%b", s, bus1.y, bus1.y_valid, exp, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    logic [3:0] exp;
    seq[0] = 2'd2; seq[1] = 2'd0; seq[2] = 2'd3; seq[3] = 2'd1;
    bus1.d = 1'b1; bus1.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.sel = seq[i];
      tick();
      exp = 4'b0001 << seq[i];
      n_cmp++;
      if (bus1.y !== exp || bus1.y_valid !== exp) begin
        n_err++; $display("FAIL b2b[%0d] y=%b v=%b want %b/%b", i, bus1.y, bus1.y_valid, exp, exp);
      end
    end
  endtask

  task automatic test_zero_data();
    bus1.d = 1'b0; bus1.sel = 2'd2; bus1.en = 1'b1;
    tick();
    n_cmp++;
    if (bus1.y !== 4'b0000 || bus1.y_valid !== 4'b0100) begin
      n_err++; $display("FAIL zero_data y=%b v=%b want 0000/0100", bus1.y, bus1.y_valid);
    end
  endtask

  task automatic test_hold();
    bus1.d = 1'b1; bus1.sel = 2'd3; bus1.en = 1'b1;
    tick();
    n_cmp++;
    if (bus1.y !== 4'b1000 || bus1.y_valid !== 4'b1000) begin
      n_err++; $display("FAIL hold_load y=%b v=%b want 1000/1000", bus1.y, bus1.y_valid);
    end
    bus1.en = 1'b0; bus1.sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus1.y !== 4'b1000 || bus1.y_valid !== 4'b1000) begin
        n_err++; $display("FAIL hold[%0d] y=%b v=%b want 1000/1000", i, bus1.y, bus1.y_valid);
      end
    end
    bus1.en = 1'b1;
    tick();
    n_cmp++;
    if (bus1.y !== 4'b0001 || bus1.y_valid !== 4'b0001) begin
      n_err++; $display("FAIL hold_resume y=%b v=%b want 0001/0001", bus1.y, bus1.y_valid);
    end
  endtask

  task automatic test_wide();
    bus8.d = 8'hA5; bus8.sel = 2'd1; bus8.en = 1'b1;
    tick();
    n_cmp++;
    if (bus8.y !== 32'h0000_A500 || bus8.y_valid !== 4'b0010) begin
      n_err++; $display("FAIL wide_sel1 y=%h v=%b want 0000a500/0010", bus8.y, bus8.y_valid);
    end
    bus8.d = 8'h3C; bus8.sel = 2'd3;
    tick();
    n_cmp++;
    if (bus8.y !== 32'h3C00_0000 || bus8.y_valid !== 4'b1000) begin
      n_err++; $display("FAIL wide_sel3 y=%h v=%b want 3c000000/1000", bus8.y, bus8.y_valid);
    end
    bus8.d = 8'hFF; bus8.sel = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus8.y !== 32'h0 || bus8.y_valid !== 4'b0000) begin
      n_err++; $display("FAIL wide_reset y=%h v=%b want 00000000/0000", bus8.y, bus8.y_valid);
    end
    #3 rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bus8.y !== 32'h0000_00FF || bus8.y_valid !== 4'b0001) begin
      n_err++; $display("FAIL wide_after_reset y=%h v=%b want 000000ff/0001", bus8.y, bus8.y_valid);
    end
  endtask

  task automatic test_comb();
    // Hold reset low and clock-independent timing to show both are ignored
    rst_n = 1'b0;
    busc.en = 1'b0; busc.d = 1'b1; busc.sel = 2'd0;
    #1;
    n_cmp++;
    if (busc.y !== 4'b0001 || busc.y_valid !== 4'b0001) begin
      n_err++; $display("FAIL comb_sel0 y=%b v=%b want 0001/0001", busc.y, busc.y_valid);
    end
    busc.sel = 2'd3;
    #1;
    n_cmp++;
    if (busc.y !== 4'b1000 || busc.y_valid !== 4'b1000) begin
      n_err++; $display("FAIL comb_sel3 y=%b v=%b want 1000/1000", busc.y, busc.y_valid);
    end
    busc.d = 1'b0; busc.sel = 2'd1;
    #1;
    n_cmp++;
    if (busc.y !== 4'b0000 || busc.y_valid !== 4'b0010) begin
      n_err++; $display("FAIL comb_zero y=%b v=%b want 0000/0010", busc.y, busc.y_valid);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    busc.d = 1'b0; busc.sel = 2'd0; busc.en = 1'b0;
    test_reset();
    test_sweep();
    test_back_to_back();
    test_zero_data();
    test_hold();
    test_wide();
    test_comb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
